// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between pipeline stages: HEAD drives the outputs, SKID
// catches one extra beat so in_ready is a pure register decode.
module pipe_stage_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TGT_W  = 28,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_jump,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [TGT_W-1:0]  in_target,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_jump,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_rt,
  output logic [DATA_W-1:0] out_target,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] jump;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rt;
    logic [TGT_W-1:0]  target;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state, state_nxt;
  beat_t  head, skid, in_beat;
  logic   head_vld, skid_vld;
  logic   accept, pop;
  logic   head_ld_in, head_ld_skid, skid_ld_in;

  assign in_beat = '{pc: in_pc, a: in_a, b: in_b, jump: in_jump,
                     rd: in_rd, rt: in_rt, target: in_target, ctrl: in_ctrl};

  // Entry valid bits are decoded from the state register so they can never disagree.
  assign head_vld = (state != EMPTY);
  assign skid_vld = (state == TWO);

  assign in_ready  = ~skid_vld;
  assign out_valid = head_vld;
  assign level     = state;

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld_in   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt  = ONE;
          head_ld_in = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            head_ld_in = 1'b1;
          end else if (accept) begin
            state_nxt  = TWO;
            skid_ld_in = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_nxt    = ONE;
          head_ld_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             head <= '0;
    else if (head_ld_in)   head <= in_beat;
    else if (head_ld_skid) head <= skid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           skid <= '0;
    else if (skid_ld_in) skid <= in_beat;
  end

  assign out_pc     = head.pc;
  assign out_a      = head.a;
  assign out_b      = head.b;
  assign out_jump   = head.jump;
  assign out_rd     = head.rd;
  assign out_rt     = head.rt;
  assign out_target = {head.pc[DATA_W-1:TGT_W], head.target};
  // An empty stage must look like a bubble downstream.
  assign out_ctrl   = head_vld ? head.ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Drives a default-width and a 64-bit instance in lockstep from one vector table.
module tb_pipe_stage_buffer;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic in_valid, out_ready, flush;
  logic [10:0] ctrl;

  logic [31:0] pc32, a32, b32, j32;
  logic [4:0]  rd32, rt32;
  logic [27:0] tg32;
  logic        ir32, ov32;
  logic [31:0] opc32, oa32, ob32, oj32, otg32;
  logic [4:0]  ord32, ort32;
  logic [10:0] octl32;
  logic [1:0]  lvl32;

  logic [63:0] pc64, a64, b64, j64;
  logic [5:0]  rd64, rt64;
  logic [57:0] tg64;
  logic        ir64, ov64;
  logic [63:0] opc64, oa64, ob64, oj64, otg64;
  logic [5:0]  ord64, ort64;
  logic [10:0] octl64;
  logic [1:0]  lvl64;

  int n_chk = 0, n_fail = 0;

  pipe_stage_buffer u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir32),
    .in_pc(pc32), .in_a(a32), .in_b(b32), .in_jump(j32), .in_rd(rd32), .in_rt(rt32),
    .in_target(tg32), .in_ctrl(ctrl), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
    .out_pc(opc32), .out_a(oa32), .out_b(ob32), .out_jump(oj32), .out_rd(ord32), .out_rt(ort32),
    .out_target(otg32), .out_ctrl(octl32), .level(lvl32));

  pipe_stage_buffer #(.DATA_W(64), .REG_W(6), .TGT_W(58), .CTRL_W(11)) u64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir64),
    .in_pc(pc64), .in_a(a64), .in_b(b64), .in_jump(j64), .in_rd(rd64), .in_rt(rt64),
    .in_target(tg64), .in_ctrl(ctrl), .flush(flush), .out_valid(ov64), .out_ready(out_ready),
    .out_pc(opc64), .out_a(oa64), .out_b(ob64), .out_jump(oj64), .out_rd(ord64), .out_rt(ort64),
    .out_target(otg64), .out_ctrl(octl64), .level(lvl64));

  // Every beat field is derived from its 32-bit tag pc so expectations follow from the tag.
  function automatic logic [63:0] fx(logic [31:0] pc);   return {~pc, pc}; endfunction
  function automatic logic [63:0] fa(logic [31:0] pc);   return fx(pc) ^ 64'hA5A5_5A5A_0F0F_F0F0; endfunction
  function automatic logic [63:0] fb(logic [31:0] pc);   return fx(pc) + 64'd3; endfunction
  function automatic logic [63:0] fj(logic [31:0] pc);   return ~fx(pc); endfunction
  function automatic logic [5:0]  frd(logic [31:0] pc);  return pc[7:2] ^ 6'h15; endfunction
  function automatic logic [5:0]  frt(logic [31:0] pc);  return pc[13:8]; endfunction
  function automatic logic [57:0] ftg(logic [31:0] pc);
    logic [63:0] x;
    x = fx(pc);
    return x[63:6] ^ 58'h155;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rdy, input logic fl, input logic [31:0] pc,
                       input logic [10:0] c);
    logic [63:0] x, a, b, j;
    logic [5:0]  rd, rt;
    logic [57:0] tg;
    x = fx(pc); a = fa(pc); b = fb(pc); j = fj(pc);
    rd = frd(pc); rt = frt(pc); tg = ftg(pc);
    in_valid = v; out_ready = rdy; flush = fl; ctrl = c;
    pc64 = x; a64 = a; b64 = b; j64 = j; rd64 = rd; rt64 = rt; tg64 = tg;
    pc32 = x[31:0]; a32 = a[31:0]; b32 = b[31:0]; j32 = j[31:0];
    rd32 = rd[4:0]; rt32 = rt[4:0]; tg32 = tg[27:0];
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] pc);
    logic [63:0] x, a, b, j;
    logic [5:0]  rd, rt;
    logic [57:0] tg;
    x = fx(pc); a = fa(pc); b = fb(pc); j = fj(pc);
    rd = frd(pc); rt = frt(pc); tg = ftg(pc);
    chk({tag, " pc32"}, 64'(opc32), 64'(x[31:0]));
    chk({tag, " a32"},  64'(oa32),  64'(a[31:0]));
    chk({tag, " b32"},  64'(ob32),  64'(b[31:0]));
    chk({tag, " j32"},  64'(oj32),  64'(j[31:0]));
    chk({tag, " rd32"}, 64'(ord32), 64'(rd[4:0]));
    chk({tag, " rt32"}, 64'(ort32), 64'(rt[4:0]));
    chk({tag, " tgt32"}, 64'(otg32), 64'({x[31:28], tg[27:0]}));
    chk({tag, " pc64"}, opc64, x);
    chk({tag, " a64"},  oa64, a);
    chk({tag, " b64"},  ob64, b);
    chk({tag, " j64"},  oj64, j);
    chk({tag, " rd64"}, 64'(ord64), 64'(rd));
    chk({tag, " rt64"}, 64'(ort64), 64'(rt));
    chk({tag, " tgt64"}, otg64, {x[63:58], tg});
  endtask

  task automatic chk_status(input string tag, input logic ov, input logic ir, input logic [1:0] lv,
                            input logic [10:0] c);
    chk({tag, " ov32"},  64'(ov32),  64'(ov));
    chk({tag, " ir32"},  64'(ir32),  64'(ir));
    chk({tag, " lvl32"}, 64'(lvl32), 64'(lv));
    chk({tag, " ctl32"}, 64'(octl32), 64'(c));
    chk({tag, " ov64"},  64'(ov64),  64'(ov));
    chk({tag, " ir64"},  64'(ir64),  64'(ir));
    chk({tag, " lvl64"}, 64'(lvl64), 64'(lv));
    chk({tag, " ctl64"}, 64'(octl64), 64'(c));
  endtask

  typedef struct {
    logic v, rdy, fl;
    logic [31:0] pc;
    logic [10:0] c;
    logic e_ov, e_ir;
    logic [1:0] e_lv;
    logic [31:0] e_pc;
    logic [10:0] e_c;
  } vec_t;

  vec_t vt[24];

  initial begin
    //        v  rdy fl  pc            ctrl      ov ir lvl  head pc       ctrl
    vt[0]  = '{1, 1, 0, 32'h0040_0000, 11'h401, 1, 1, 2'd1, 32'h0040_0000, 11'h401}; // pass-through
    vt[1]  = '{1, 1, 0, 32'h0040_0004, 11'h202, 1, 1, 2'd1, 32'h0040_0004, 11'h202};
    vt[2]  = '{1, 1, 0, 32'h0040_0008, 11'h104, 1, 1, 2'd1, 32'h0040_0008, 11'h104};
    vt[3]  = '{0, 1, 0, 32'h0,         11'h000, 0, 1, 2'd0, 32'h0,         11'h000};
    vt[4]  = '{1, 0, 0, 32'h1000_0000, 11'h7FF, 1, 1, 2'd1, 32'h1000_0000, 11'h7FF}; // backpressure
    vt[5]  = '{1, 0, 0, 32'h2000_0010, 11'h055, 1, 0, 2'd2, 32'h1000_0000, 11'h7FF};
    vt[6]  = '{1, 0, 0, 32'h3000_0000, 11'h0AA, 1, 0, 2'd2, 32'h1000_0000, 11'h7FF};
    vt[7]  = '{0, 1, 0, 32'h0,         11'h000, 1, 1, 2'd1, 32'h2000_0010, 11'h055};
    vt[8]  = '{0, 1, 0, 32'h0,         11'h000, 0, 1, 2'd0, 32'h0,         11'h000};
    vt[9]  = '{1, 0, 0, 32'h4000_0000, 11'h011, 1, 1, 2'd1, 32'h4000_0000, 11'h011}; // flush at 2
    vt[10] = '{1, 0, 0, 32'h5000_0000, 11'h022, 1, 0, 2'd2, 32'h4000_0000, 11'h011};
    vt[11] = '{1, 1, 1, 32'h6000_0000, 11'h033, 0, 1, 2'd0, 32'h0,         11'h000};
    vt[12] = '{0, 1, 0, 32'h0,         11'h000, 0, 1, 2'd0, 32'h0,         11'h000};
    vt[13] = '{1, 0, 0, 32'h7000_0000, 11'h044, 1, 1, 2'd1, 32'h7000_0000, 11'h044}; // flush at 1
    vt[14] = '{1, 1, 1, 32'h7100_0000, 11'h055, 0, 1, 2'd0, 32'h0,         11'h000};
    vt[15] = '{1, 1, 0, 32'h7200_0000, 11'h066, 1, 1, 2'd1, 32'h7200_0000, 11'h066};
    vt[16] = '{1, 1, 0, 32'h7300_0000, 11'h077, 1, 1, 2'd1, 32'h7300_0000, 11'h077};
    vt[17] = '{0, 1, 0, 32'h0,         11'h000, 0, 1, 2'd0, 32'h0,         11'h000};
    vt[18] = '{1, 1, 1, 32'h7400_0000, 11'h088, 0, 1, 2'd0, 32'h0,         11'h000}; // flush empty
    vt[19] = '{1, 0, 0, 32'h8000_0000, 11'h001, 1, 1, 2'd1, 32'h8000_0000, 11'h001}; // pop from 2
    vt[20] = '{1, 0, 0, 32'h8100_0000, 11'h002, 1, 0, 2'd2, 32'h8000_0000, 11'h001};
    vt[21] = '{1, 1, 0, 32'h8200_0000, 11'h004, 1, 1, 2'd1, 32'h8100_0000, 11'h002};
    vt[22] = '{1, 1, 0, 32'h8200_0000, 11'h004, 1, 1, 2'd1, 32'h8200_0000, 11'h004};
    vt[23] = '{0, 1, 0, 32'h0,         11'h000, 0, 1, 2'd0, 32'h0,         11'h000};

    drive(0, 0, 0, 32'h0, 11'h0);
    #1;
    chk_status("reset", 1'b0, 1'b1, 2'd0, 11'h0);
    chk("reset opc32", 64'(opc32), 64'h0);
    chk("reset otg64", otg64, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].v, vt[i].rdy, vt[i].fl, vt[i].pc, vt[i].c);
      @(posedge clk);
      #1;
      chk_status($sformatf("row%0d", i), vt[i].e_ov, vt[i].e_ir, vt[i].e_lv, vt[i].e_c);
      if (vt[i].e_ov) chk_beat($sformatf("row%0d", i), vt[i].e_pc);
    end

    // Jump target built from the stored pc, stable under backpressure.
    drive(1, 1, 0, 32'hA000_1234, 11'h3C0);
    pc32 = 32'hA000_1234;            tg32 = 28'h0AB_CDEF;
    pc64 = 64'hA000_0000_0000_1234;  tg64 = 58'h0AB_CDEF;
    @(posedge clk);
    #1;
    chk("tgt32", 64'(otg32), 64'hA0AB_CDEF);
    chk("tgt64", otg64, 64'hA000_0000_00AB_CDEF);
    drive(0, 0, 0, 32'h5555_0000, 11'h0);
    @(posedge clk);
    #1;
    chk("tgt32 hold", 64'(otg32), 64'hA0AB_CDEF);
    chk("tgt64 hold", otg64, 64'hA000_0000_00AB_CDEF);
    chk("pc32 hold", 64'(opc32), 64'hA000_1234);
    chk_status("tgt hold", 1'b1, 1'b1, 2'd1, 11'h3C0);
    drive(0, 1, 0, 32'h0, 11'h0);
    @(posedge clk);
    #1;
    chk_status("tgt drain", 1'b0, 1'b1, 2'd0, 11'h0);

    // Asynchronous reset while full, then the first beat after release.
    drive(1, 0, 0, 32'hC000_0000, 11'h123);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 32'hC100_0000, 11'h321);
    @(posedge clk);
    #1;
    chk_status("prefill", 1'b1, 1'b0, 2'd2, 11'h123);
    #2;
    reset = 1'b1;
    #1;
    chk_status("async rst", 1'b0, 1'b1, 2'd0, 11'h0);
    chk("async rst opc32", 64'(opc32), 64'h0);
    chk("async rst oa64", oa64, 64'h0);
    chk("async rst otg32", 64'(otg32), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 0, 32'hD000_0000, 11'h2AA);
    @(posedge clk);
    #1;
    chk_status("post rst", 1'b1, 1'b1, 2'd1, 11'h2AA);
    chk_beat("post rst", 32'hD000_0000);
    drive(0, 1, 0, 32'h0, 11'h0);
    @(posedge clk);
    #1;
    chk_status("post rst drain", 1'b0, 1'b1, 2'd0, 11'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameters: name, default, meaning:
- DATA_W, 32, operand/PC width.
- REG_W, 5, register-index width.
- TGT_W, 28, jump-target field width; SHALL be < DATA_W.
- CTRL_W, 11, control-bundle width: {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ControlJump, ALUOP[2:0]}, MSB first.

REQ-002 Ports: name, direction, width, meaning (clock and reset first):
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous active-high reset.
- in_valid, in, 1, upstream beat present.
- in_ready, out, 1, buffer can accept a beat.
- in_pc, in, DATA_W, fetch PC.
- in_a, in, DATA_W, operand A.
- in_b, in, DATA_W, operand B.
- in_jump, in, DATA_W, sign-extended immediate.
- in_rd, in, REG_W, rd index.
- in_rt, in, REG_W, rt index.
- in_target, in, TGT_W, jump-target field.
- in_ctrl, in, CTRL_W, control bundle.
- flush, in, 1, synchronous discard of all held and incoming beats.
- out_valid, out, 1, head beat present.
- out_ready, in, 1, downstream accepts head beat.
- out_pc, out_a, out_b, out_jump, out, DATA_W each, head-beat fields.
- out_rd, out_rt, out, REG_W each, head-beat fields.
- out_target, out, DATA_W, {head pc[DATA_W-1:TGT_W], head target}.
- out_ctrl, out, CTRL_W, head control; all-zero when out_valid=0.
- level, out, 2, beats held (0..2).

Function
REQ-003 Storage: two entries, HEAD (drives outputs) and SKID; each holds every in_* field plus a valid bit.
REQ-004 States: EMPTY (level 0), ONE (HEAD valid), TWO (HEAD and SKID valid).
REQ-005 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only, with no combinational path from out_ready.
REQ-006 Accept = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
REQ-007 Transitions:
- EMPTY + accept -> ONE, beat to HEAD.
- ONE + accept & ~pop -> TWO, beat to SKID.
- ONE + accept & pop -> ONE, beat to HEAD.
- ONE + pop & ~accept -> EMPTY.
- TWO + pop -> ONE, SKID moves to HEAD.
- Otherwise, hold.
REQ-008 Latency: an accepted beat SHALL appear on out_* the cycle after acceptance when the buffer was EMPTY, or ONE with a simultaneous pop.
REQ-009 Order: beats SHALL exit in acceptance order; none duplicated or lost except by flush.
REQ-010 Held beat: while out_valid=1 and out_ready=0, every out_* SHALL remain stable.
REQ-011 flush=1: next state EMPTY, both valid bits cleared, out_ctrl forced to zero, and the beat on in_* dropped, regardless of in_valid/out_ready.
REQ-012 flush has priority over accept and pop in the same cycle.
REQ-013 out_target SHALL be formed from the stored pc and target of the head beat, not live inputs.
REQ-014 out_ctrl SHALL equal the HEAD control field when out_valid=1 and zero otherwise, so an empty stage is a bubble.
REQ-015 level SHALL equal 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-016 reset=1 SHALL immediately force:
- state EMPTY, level=0, out_valid=0, in_ready=1;
- all out_* data/control outputs to zero.
REQ-017 Reset SHALL take effect mid-transfer with no completion of an in-flight beat; first accept is possible on the first rising edge after reset deasserts.

Verification
REQ-018 Pass-through: out_ready=1, beats pc=0x00400000,0x00400004,0x00400008 back-to-back -> each appears one cycle later in order; level stays 1; in_ready stays 1.
REQ-019 Backpressure: out_ready=0, push A then B -> level=2, in_ready=0, out_* hold A; raise out_ready -> A, then B, on consecutive cycles.
REQ-020 Target: pc=0xA0001234, target=0x0ABCDEF -> out_target=0xA0ABCDEF.
REQ-021 Flush: level=2 plus valid input with flush=1 -> next cycle level=0, out_valid=0, out_ctrl=0; none of the three beats ever emerges.
REQ-022 Async reset: assert reset between clock edges while level=2 -> outputs zero before next edge; after release, first beat passes normally.
REQ-023 Parameter sweep: DATA_W=64, TGT_W=58, REG_W=6 -> REQ-018..REQ-021 pass with widths scaled.
